// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: privilege-side trap/return controller.
// Arbitrates pending interrupts, pipeline exceptions and mret. It latches
// the winning event, waits for the pipeline to drain (bounded by
// DRAIN_TIMEOUT), and then issues a one-cycle redirect plus either a trap
// record for the CSR file or an mret_done pulse.
// Optional feature macro: TRAP_VECTORED_EN enables vectored interrupt entry
// when mtvec[1:0]==2'b01. When it is undefined, mtvec[1:0] is ignored.
module priv_trap_ctrl #(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [11:0]     exc_flags,
    input  logic [1:0]      curr_priv,
    input  logic [2:0]      irq_pend,
    input  logic [2:0]      mie_en,
    input  logic            mstatus_mie,
    input  logic            mret,
    input  logic            pipe_clear,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] badaddr,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_r,
    output logic            intr,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    output logic            trap_we,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] tval,
    output logic [XLEN-1:0] mepc_w,
    output logic            mret_done,
    output logic            drain_to
);

    localparam int CW = $clog2(DRAIN_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_is_mret;
    logic [XLEN-1:0] r_target;
    logic            r_intr;
    logic            r_insert_pc;
    logic [XLEN-1:0] r_priv_pc;
    logic            r_trap_we;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_mepc_w;
    logic            r_mret_done;
    logic            r_drain_to;

    logic [2:0]      w_take;
    logic            w_irq_any;
    logic            w_exc_any;
    logic            w_event;
    logic [4:0]      w_irq_code;
    logic [3:0]      w_exc_idx;
    logic [4:0]      w_exc_code;
    logic [XLEN-1:0] w_exc_tval;
    logic [4:0]      w_code;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_target;

    assign w_take    = irq_pend & mie_en & {3{mstatus_mie}};
    assign w_irq_any = |w_take;
    assign w_exc_any = |exc_flags;
    assign w_event   = w_irq_any | w_exc_any | mret;
    assign w_base    = {mtvec[XLEN-1:2], 2'b00};

    // Interrupt code: external beats software beats timer.
    always_comb begin
        w_irq_code = 5'd0;
        if (w_take[2])      w_irq_code = 5'd11;
        else if (w_take[0]) w_irq_code = 5'd3;
        else if (w_take[1]) w_irq_code = 5'd7;
    end

    // Exception select: the lowest set flag index wins, so scan downward.
    always_comb begin
        w_exc_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (exc_flags[i]) w_exc_idx = 4'(i);
        end
    end

    // Map the winning exception to its mcause code and mtval value.
    always_comb begin
        w_exc_code = 5'd0;
        w_exc_tval = badaddr;
        case (w_exc_idx)
            4'd0:    begin w_exc_code = 5'd3;  w_exc_tval = epc; end
            4'd1:    w_exc_code = 5'd12;
            4'd2:    w_exc_code = 5'd1;
            4'd3:    begin w_exc_code = 5'd2;  w_exc_tval = '0; end
            4'd4:    w_exc_code = 5'd0;
            4'd5:    begin w_exc_code = 5'd8 + {3'd0, curr_priv}; w_exc_tval = '0; end
            4'd6:    w_exc_code = 5'd4;
            4'd7:    w_exc_code = 5'd6;
            4'd8:    w_exc_code = 5'd13;
            4'd9:    w_exc_code = 5'd15;
            4'd10:   w_exc_code = 5'd5;
            default: w_exc_code = 5'd7;
        endcase
    end

    // Build the full mcause word and the trap entry address.
    always_comb begin
        w_code              = w_irq_any ? w_irq_code : w_exc_code;
        w_cause             = XLEN'(w_code);
        w_cause[XLEN-1]     = w_irq_any;
`ifdef TRAP_VECTORED_EN
        if (w_irq_any && (mtvec[1:0] == 2'b01))
            w_trap_target = w_base + XLEN'({w_irq_code, 2'b00});
        else
            w_trap_target = w_base;
`else
        w_trap_target = w_base;
`endif
    end

    // Trap/return sequencer: IDLE -> DRAIN -> REDIRECT, all outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_mret   <= 1'b0;
            r_target    <= '0;
            r_intr      <= 1'b0;
            r_insert_pc <= 1'b0;
            r_priv_pc   <= '0;
            r_trap_we   <= 1'b0;
            r_cause     <= '0;
            r_tval      <= '0;
            r_mepc_w    <= '0;
            r_mret_done <= 1'b0;
            r_drain_to  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_insert_pc <= 1'b0;
                    r_trap_we   <= 1'b0;
                    r_mret_done <= 1'b0;
                    r_cnt       <= '0;
                    if (w_event) begin
                        r_intr  <= 1'b1;
                        r_state <= ST_DRAIN;
                        if (w_irq_any || w_exc_any) begin
                            r_is_mret <= 1'b0;
                            r_cause   <= w_cause;
                            r_tval    <= w_irq_any ? '0 : w_exc_tval;
                            r_mepc_w  <= epc;
                            r_target  <= w_trap_target;
                        end else begin
                            r_is_mret <= 1'b1;
                            r_target  <= mepc_r;
                        end
                    end
                end
                ST_DRAIN: begin
                    // New events are ignored here; the latched one is final.
                    if (pipe_clear || (r_cnt == CW'(DRAIN_TIMEOUT - 1))) begin
                        r_state     <= ST_REDIRECT;
                        r_insert_pc <= 1'b1;
                        r_priv_pc   <= r_target;
                        r_trap_we   <= ~r_is_mret;
                        r_mret_done <= r_is_mret;
                        if (!pipe_clear) r_drain_to <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_intr      <= 1'b0;
                    r_insert_pc <= 1'b0;
                    r_trap_we   <= 1'b0;
                    r_mret_done <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign intr      = r_intr;
    assign insert_pc = r_insert_pc;
    assign priv_pc   = r_priv_pc;
    assign trap_we   = r_trap_we;
    assign cause     = r_cause;
    assign tval      = r_tval;
    assign mepc_w    = r_mepc_w;
    assign mret_done = r_mret_done;
    assign drain_to  = r_drain_to;

endmodule
